freq_edge_counter: RTL and testbench

Downstream consumer of the frequency divider. Takes one divided output (freq2 or freq4) as a level input. Detects each rising edge on the system clock and emits a one-cycle pulse per edge. Counts edges modulo MOD_N and measures the input period in clk cycles with saturation, so divider outputs can be checked and used as clock enables rather than as clocks.

---
 rtl/freq_pkg.sv | 13 +
 rtl/edge_detect_sync.sv | 39 +++
 rtl/freq_edge_counter.sv | 85 ++++++++
 tb/tb_freq_edge_counter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// Shared defaults and helpers for the freq_edge_counter block.
package freq_pkg;

  localparam int unsigned DEF_CNT_W = 8;
  localparam int unsigned DEF_PER_W = 8;
  localparam int unsigned DEF_MOD_N = 10;

  // Increment v by one, clamping at max_v.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/edge_detect_sync.sv
// Rising-edge detector for freq_in; FREQ_EDGE_SYNC_EN adds a 2-flop synchronizer in front.
module edge_detect_sync (
  input  logic clk,
  input  logic reset_in,
  input  logic freq_in,
  output logic rise
);

  logic s;
  logic prev;

`ifdef FREQ_EDGE_SYNC_EN
  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (!reset_in) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= freq_in;
      s2 <= s1;
    end
  end

  assign s = s2;
`else
  assign s = freq_in;
`endif

  // prev resets low so an input already high at reset release still yields one rise.
  always_ff @(posedge clk) begin
    if (!reset_in) prev <= 1'b0;
    else           prev <= s;
  end

  assign rise = s & ~prev;

endmodule

// File: rtl/freq_edge_counter.sv
// Edge pulse, modulo edge counter and saturating period meter for a divided clock.
// Build option FREQ_EDGE_SYNC_EN (inside edge_detect_sync) synchronizes freq_in first.
module freq_edge_counter
  import freq_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned PER_W = DEF_PER_W,
  parameter int unsigned MOD_N = DEF_MOD_N
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             freq_in,
  input  logic             en,
  input  logic             clr,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic [PER_W-1:0] period,
  output logic             period_valid,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOD_N - 1);
  localparam logic [PER_W-1:0] PER_MAX  = '1;

  logic             rise;
  logic             armed;
  logic [PER_W-1:0] cyc;
  logic [PER_W-1:0] cyc_inc;

  edge_detect_sync u_edge (
    .clk      (clk),
    .reset_in (reset_in),
    .freq_in  (freq_in),
    .rise     (rise)
  );

  assign cyc_inc = PER_W'(sat_inc(32'(cyc), 32'(PER_MAX)));

  always_ff @(posedge clk) begin
    if (!reset_in) begin
      edge_pulse   <= 1'b0;
      count        <= '0;
      wrap         <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      overflow     <= 1'b0;
      cyc          <= '0;
      armed        <= 1'b0;
    end else begin
      edge_pulse   <= 1'b0;
      wrap         <= 1'b0;
      period_valid <= 1'b0;
      if (clr) begin
        count    <= '0;
        cyc      <= '0;
        period   <= '0;
        armed    <= 1'b0;
        overflow <= 1'b0;
      end else begin
        cyc <= cyc_inc;
        if (rise) begin
          edge_pulse <= 1'b1;
          cyc        <= '0;
          if (en) begin
            if (count == CNT_LAST) begin
              count <= '0;
              wrap  <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
          // cyc counts from 0 after the previous rise, so the period is cyc+1.
          if (armed) begin
            period       <= cyc_inc;
            period_valid <= 1'b1;
            if (cyc == PER_MAX) overflow <= 1'b1;
          end
          armed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_freq_edge_counter.sv
// Self-checking bench for freq_edge_counter: vector table, directed corner sequences, random vs model.
module tb_freq_edge_counter;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned PER_W = 8;
  localparam int unsigned MOD_N = 10;
  localparam int PER_SAT = (1 << PER_W) - 1;
`ifdef FREQ_EDGE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic             clk = 1'b0;
  logic             reset_in = 1'b0;
  logic             freq_in = 1'b0;
  logic             en = 1'b0;
  logic             clr = 1'b0;
  logic             edge_pulse;
  logic [CNT_W-1:0] count;
  logic             wrap;
  logic [PER_W-1:0] period;
  logic             period_valid;
  logic             overflow;

  always #5 clk = ~clk;

  freq_edge_counter #(.CNT_W(CNT_W), .PER_W(PER_W), .MOD_N(MOD_N)) dut (
    .clk          (clk),
    .reset_in     (reset_in),
    .freq_in      (freq_in),
    .en           (en),
    .clr          (clr),
    .edge_pulse   (edge_pulse),
    .count        (count),
    .wrap         (wrap),
    .period       (period),
    .period_valid (period_valid),
    .overflow     (overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int seen_edge = 0;
  int seen_wrap = 0;
  int seen_pv = 0;

  // Reference model: edges in time, period = distance between consecutive rises.
  int m_count = 0;
  int m_period = 0;
  int t_now = 0;
  int last_rise = 0;
  bit m_edge = 0, m_wrap = 0, m_pv = 0, m_ovf = 0, m_armed = 0, m_prev = 0;
  bit dly[$];

  typedef struct {
    bit f;
    bit e;
    bit x_edge;
    int x_count;
    bit x_wrap;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit f, input bit e, input bit c, input bit r);
    bit s;
    bit rise;
    int el;
    t_now++;
    m_edge = 0; m_wrap = 0; m_pv = 0;
    if (!r) begin
      m_count = 0; m_period = 0; m_ovf = 0; m_armed = 0; m_prev = 0;
      dly.delete();
      for (int i = 0; i < LAT; i++) dly.push_back(1'b0);
      return;
    end
    dly.push_back(f);
    s = dly.pop_front();
    rise = s && !m_prev;
    m_prev = s;
    if (c) begin
      m_count = 0; m_period = 0; m_armed = 0; m_ovf = 0;
      return;
    end
    if (rise) begin
      m_edge = 1;
      if (e) begin
        m_count = (m_count + 1) % MOD_N;
        m_wrap = (m_count == 0);
      end
      if (m_armed) begin
        el = t_now - last_rise;
        m_period = (el > PER_SAT) ? PER_SAT : el;
        m_pv = 1;
        if (el > PER_SAT) m_ovf = 1;
      end
      m_armed = 1;
      last_rise = t_now;
    end
  endtask

  task automatic step(input bit f, input bit e, input bit c, input bit r, input bit mchk);
    freq_in = f; en = e; clr = c; reset_in = r;
    @(posedge clk);
    model_edge(f, e, c, r);
    @(negedge clk);
    seen_edge += int'(edge_pulse);
    seen_wrap += int'(wrap);
    seen_pv   += int'(period_valid);
    if (mchk) begin
      chk("edge_pulse", int'(edge_pulse), int'(m_edge));
      chk("count", int'(count), m_count);
      chk("wrap", int'(wrap), int'(m_wrap));
      chk("period", int'(period), m_period);
      chk("period_valid", int'(period_valid), int'(m_pv));
      chk("overflow", int'(overflow), int'(m_ovf));
    end
  endtask

  task automatic grp4(input bit e, input int n);
    for (int i = 0; i < n; i++) begin
      step(1, e, 0, 1, 1);
      step(1, e, 0, 1, 1);
      step(0, e, 0, 1, 1);
      step(0, e, 0, 1, 1);
    end
  endtask

  task automatic clear_seen();
    seen_edge = 0; seen_wrap = 0; seen_pv = 0;
  endtask

  initial begin
    // {freq_in, en, expected edge_pulse, count, wrap}
    tbl[0]  = '{1, 1, 1, 1, 0};
    tbl[1]  = '{0, 1, 0, 1, 0};
    tbl[2]  = '{1, 1, 1, 2, 0};
    tbl[3]  = '{0, 0, 0, 2, 0};
    tbl[4]  = '{1, 0, 1, 2, 0};
    tbl[5]  = '{1, 1, 0, 2, 0};
    tbl[6]  = '{0, 1, 0, 2, 0};
    tbl[7]  = '{1, 1, 1, 3, 0};
    tbl[8]  = '{1, 1, 0, 3, 0};
    tbl[9]  = '{1, 1, 0, 3, 0};
    tbl[10] = '{0, 1, 0, 3, 0};
    tbl[11] = '{1, 0, 1, 3, 0};
    tbl[12] = '{0, 1, 0, 3, 0};
    tbl[13] = '{1, 1, 1, 4, 0};

    // Reset state
    step(0, 0, 0, 0, 1);

    // Table: en is delayed by LAT so it lines up with the rise the DUT sees
    for (int j = 0; j < 14 + LAT; j++) begin
      bit f;
      bit e;
      f = (j < 14) ? tbl[j].f : 1'b0;
      e = (j >= LAT) ? tbl[j - LAT].e : 1'b1;
      step(f, e, 0, 1, 0);
      if (j >= LAT) begin
        chk("tbl_edge", int'(edge_pulse), int'(tbl[j - LAT].x_edge));
        chk("tbl_count", int'(count), tbl[j - LAT].x_count);
        chk("tbl_wrap", int'(wrap), int'(tbl[j - LAT].x_wrap));
      end
    end

    // Steady freq4: ten edges, one wrap, period 4
    step(0, 1, 0, 0, 1);
    clear_seen();
    grp4(1, 10);
    chk("f4_edges", seen_edge, 10);
    chk("f4_wraps", seen_wrap, 1);
    chk("f4_count", int'(count), 0);
    chk("f4_pv", seen_pv, 9);
    chk("f4_period", int'(period), 4);

    // Switch to freq2
    clear_seen();
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0, 1, 1);
      step(0, 1, 0, 1, 1);
    end
    step(0, 1, 0, 1, 1);
    step(0, 1, 0, 1, 1);
    chk("f2_edges", seen_edge, 6);
    chk("f2_period", int'(period), 2);

    // Saturation: long low then a rise
    for (int i = 0; i < 300; i++) step(0, 1, 0, 1, 1);
    step(1, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 1);
    chk("sat_period", int'(period), PER_SAT);
    chk("sat_ovf", int'(overflow), 1);
    grp4(1, 2);
    chk("sat_ovf_sticky", int'(overflow), 1);
    step(0, 1, 1, 1, 1);
    chk("clr_ovf", int'(overflow), 0);

    // clr coincident with a rise at count=7
    step(0, 1, 0, 0, 1);
    grp4(1, 7);
    chk("pre_clr_count", int'(count), 7);
    for (int i = 0; i < LAT; i++) step(1, 1, 0, 1, 1);
    step(1, 1, 1, 1, 1);
    chk("clr_edge", int'(edge_pulse), 0);
    chk("clr_count", int'(count), 0);
    clear_seen();
    step(1, 1, 0, 1, 1);
    step(0, 1, 0, 1, 1);
    step(0, 1, 0, 1, 1);
    step(1, 1, 0, 1, 1);
    step(1, 1, 0, 1, 1);
    step(0, 1, 0, 1, 1);
    step(0, 1, 0, 1, 1);
    chk("disarm_edges", seen_edge, 1);
    chk("disarm_pv", seen_pv, 0);
    clear_seen();
    grp4(1, 1);
    chk("rearm_pv", seen_pv, 1);

    // en low for three edges at count=5
    grp4(1, 3);
    chk("pre_en_count", int'(count), 5);
    clear_seen();
    grp4(0, 3);
    chk("en_edges", seen_edge, 3);
    chk("en_count", int'(count), 5);
    chk("en_wrap", seen_wrap, 0);

    // Reset mid-operation at count=6, freq_in high through release
    step(0, 1, 0, 0, 1);
    grp4(1, 6);
    chk("pre_rst_count", int'(count), 6);
    step(1, 1, 0, 0, 1);
    chk("rst_edge", int'(edge_pulse), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_ovf", int'(overflow), 0);
    clear_seen();
    for (int i = 0; i < LAT; i++) step(1, 1, 0, 1, 1);
    chk("rel_early", seen_edge, 0);
    step(1, 1, 0, 1, 1);
    chk("rel_edge", int'(edge_pulse), 1);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 1, 1);
    chk("rel_once", seen_edge, 1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 9) != 0),
           bit'($urandom_range(0, 29) == 0), bit'($urandom_range(0, 99) != 0), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
